nasti_stream_reader: RTL
========================

Name: nasti_stream_reader

Overview:
Memory-to-stream data mover. It accepts a (source address, word count) request and issues NASTI read bursts of up to MAX_BURST_LENGTH beats. Each burst is collected into a local buffer, then replayed on a NASTI-stream master port. It is the upstream counterpart of the stream-to-NASTI write mover; chaining the two forms a memory-to-memory copy engine.

Parameters:
ADDR_WIDTH, 64, width of request and AR addresses
DATA_WIDTH, 64, width of R data and stream data (power of two, at least 8)
MAX_BURST_LENGTH, 8, maximum beats per AR burst (power of two, at most 256)
LEN_WIDTH, 16, width of the request word count

Ports:
aclk  in  1  clock, rising edge
areset  in  1  asynchronous, active-high reset
src  nasti_channel  -  read-side NASTI master; only ar_* and r_* are driven/used; aw_valid=0, w_valid=0, b_ready=0 tied
dest  nasti_stream_channel.master  -  output stream (t_valid, t_ready, t_data, t_keep, t_strb, t_last)
r_src  in  ADDR_WIDTH  source byte address
r_len  in  LEN_WIDTH  transfer length in DATA_WIDTH words
r_valid  in  1  request valid
r_ready  out  1  idle / request accept
r_err  out  1  sticky: non-OKAY r_resp seen in current/last transfer

Behaviour:
- Reset (async, areset=1): r_ready=1, r_err=0, src.ar_valid=0, src.r_ready=0, dest.t_valid=0, dest.t_last=0, state=IDLE.
- Constant fields: ar_id=0, ar_size=log2(DATA_WIDTH/8), ar_burst=INCR (2'b01), ar_cache=0, ar_prot=0, ar_lock=0. t_keep and t_strb are all ones.
- Fire rule: a channel transfers when valid and ready are both high in the same cycle.
- IDLE (r_ready=1): on r_valid:
  - latch addr = r_src with the low log2(DATA_WIDTH/8) bits forced to 0;
  - latch remaining = r_len; clear r_err; drop r_ready.
  - If r_len==0: r_ready returns to 1 on the next cycle and nothing is emitted.
  - Otherwise go to ADDRESS.
- ADDRESS:
  - Compute burst = min(remaining, MAX_BURST_LENGTH).
  - Drive ar_valid=1, ar_addr=addr, ar_len=burst-1 (registered; first ar_valid is the cycle after request accept).
  - Hold all AR fields stable until ar fire.
  - On fire: ar_valid=0, r_ready=1, beat counter wr_ptr=0, addr += burst<<log2(DATA_WIDTH/8) (wraps modulo 2^ADDR_WIDTH), remaining -= burst. Go to READ.
- READ:
  - Each r fire writes r_data to buffer[wr_ptr] and increments wr_ptr.
  - r_resp!=0 sets r_err; the data is still stored and forwarded.
  - On the fire that carries r_last, or when wr_ptr reaches burst-1: r_ready=0, rd_ptr=0, go to STREAM.
  - r_last arriving early or late is an assertion error; the burst count is authoritative.
- STREAM:
  - t_valid=1, t_data=buffer[rd_ptr], t_last=1 only on the final beat of the whole transfer (rd_ptr==burst-1 and remaining==0).
  - Data and last are held stable while t_valid is high and t_ready is low.
  - On t fire: rd_ptr++.
  - After the last beat of the burst fires: t_valid=0. Go to ADDRESS if remaining!=0, otherwise r_ready=1 and return to IDLE.
- No overlap: the next AR is issued only after the buffer drains. Throughput is at most one burst per (AR + burst + burst) cycles.
- Buffer indices use log2(MAX_BURST_LENGTH) bits. The burst counter uses log2(MAX_BURST_LENGTH)+1 bits.
- A new r_valid while r_ready=0 is ignored.
- Reset mid-operation: all state is abandoned immediately. Outstanding NASTI beats are the interconnect's responsibility.

Decomposition:
- Shared package nasti_stream_pkg holds the AXI burst/resp constants (BURST_INCR, RESP_OKAY, RESP_SLVERR) and the state enum (IDLE, ADDRESS, READ, STREAM). The write mover can reuse them.
- Natural sub-module: nasti_burst_buffer. It is a MAX_BURST_LENGTH x DATA_WIDTH register file with one write port and one read port, and a combinational read.

Test Plan:
1. r_src=0x1000, r_len=8, memory word i = i → one AR (addr 0x1000, len 7, size 3). The stream shows 0..7, t_last only on beat 7. r_ready=1 after, r_err=0.
2. r_src=0x2000, r_len=11 → ARs at 0x2000 (len 7) and 0x2040 (len 2). 11 beats come out in order, t_last on beat 10 only.
3. r_len=0 → no ar_valid and no t_valid ever. r_ready back to 1 two cycles after the request.
4. r_len=8 with dest.t_ready toggling 1-0-0-1 and random R-channel gaps → data and order intact, t_data stable during stalls, no beat dropped or duplicated.
5. r_src=0x3005, r_len=2, second beat r_resp=SLVERR → ar_addr=0x3000. Both beats are emitted and r_err=1 until the next request.
6. areset asserted during STREAM of burst 2 of a 16-word transfer → outputs take reset values immediately. A fresh 4-word request then completes correctly.

Source files
------------

// File: rtl/nasti_stream_pkg.sv
// Shared constants and state encoding for the NASTI memory/stream movers.
// Both the reader and the writer import this package.
package nasti_stream_pkg;

    localparam int ID_WIDTH = 4;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ADDRESS = 2'd1;
    localparam state_t ST_READ    = 2'd2;
    localparam state_t ST_STREAM  = 2'd3;

endpackage

// File: rtl/nasti_burst_buffer.sv
// One-burst staging store: a single write port and a combinational read port.
module nasti_burst_buffer #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset so the stream never exposes stale X data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nasti_stream_reader.sv
// Memory-to-stream mover: fetches a request in NASTI read bursts, stages each
// burst locally, then replays it on the stream master port.
module nasti_stream_reader
    import nasti_stream_pkg::*;
#(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    // read-side NASTI master
    output logic [ID_WIDTH-1:0]     src_ar_id,
    output logic [ADDR_WIDTH-1:0]   src_ar_addr,
    output logic [7:0]              src_ar_len,
    output logic [2:0]              src_ar_size,
    output logic [1:0]              src_ar_burst,
    output logic                    src_ar_lock,
    output logic [3:0]              src_ar_cache,
    output logic [2:0]              src_ar_prot,
    output logic                    src_ar_valid,
    input  logic                    src_ar_ready,
    input  logic [DATA_WIDTH-1:0]   src_r_data,
    input  logic [1:0]              src_r_resp,
    input  logic                    src_r_last,
    input  logic                    src_r_valid,
    output logic                    src_r_ready,
    output logic                    src_aw_valid,
    output logic                    src_w_valid,
    output logic                    src_b_ready,
    // stream master
    output logic                    dest_t_valid,
    input  logic                    dest_t_ready,
    output logic [DATA_WIDTH-1:0]   dest_t_data,
    output logic [DATA_WIDTH/8-1:0] dest_t_keep,
    output logic [DATA_WIDTH/8-1:0] dest_t_strb,
    output logic                    dest_t_last,
    // request port
    input  logic [ADDR_WIDTH-1:0]   r_src,
    input  logic [LEN_WIDTH-1:0]    r_len,
    input  logic                    r_valid,
    output logic                    r_ready,
    output logic                    r_err
);

    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W     = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;
    localparam int CNT_W     = $clog2(MAX_BURST_LENGTH) + 1;
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'((64'd1 << SIZE_LOG2) - 64'd1);

    state_t                state_q,       state_d;
    logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q,   remaining_d;
    logic [CNT_W-1:0]      burst_q,       burst_d;
    logic [IDX_W-1:0]      wr_ptr_q,      wr_ptr_d;
    logic [IDX_W-1:0]      rd_ptr_q,      rd_ptr_d;
    logic [7:0]            ar_len_q,      ar_len_d;
    logic                  ar_valid_q,    ar_valid_d;
    logic                  src_r_ready_q, src_r_ready_d;
    logic                  t_valid_q,     t_valid_d;
    logic                  t_last_q,      t_last_d;
    logic                  r_ready_q,     r_ready_d;
    logic                  r_err_q,       r_err_d;

    logic                  buf_we_s;
    logic [CNT_W-1:0]      burst_req_s;
    logic [CNT_W-1:0]      burst_rem_s;
    logic                  wr_last_s;
    logic                  rd_last_s;

    function automatic logic [CNT_W-1:0] burst_of(input logic [LEN_WIDTH-1:0] rem);
        if (rem >= LEN_WIDTH'(MAX_BURST_LENGTH)) begin
            return CNT_W'(MAX_BURST_LENGTH);
        end else begin
            return rem[CNT_W-1:0];
        end
    endfunction

    assign burst_req_s = burst_of(r_len);
    assign burst_rem_s = burst_of(remaining_q);
    assign wr_last_s   = (CNT_W'(wr_ptr_q) == (burst_q - CNT_W'(1)));
    assign rd_last_s   = (CNT_W'(rd_ptr_q) == (burst_q - CNT_W'(1)));

    // Next-state logic for the IDLE/ADDRESS/READ/STREAM sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        burst_d       = burst_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ar_len_d      = ar_len_q;
        ar_valid_d    = ar_valid_q;
        src_r_ready_d = src_r_ready_q;
        t_valid_d     = t_valid_q;
        t_last_d      = t_last_q;
        r_ready_d     = r_ready_q;
        r_err_d       = r_err_q;
        buf_we_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!r_ready_q) begin
                    // zero-length request: reopen one cycle after accept
                    r_ready_d = 1'b1;
                end else if (r_valid) begin
                    addr_d      = r_src & ALIGN_MASK;
                    remaining_d = r_len;
                    r_err_d     = 1'b0;
                    r_ready_d   = 1'b0;
                    if (r_len != LEN_WIDTH'(0)) begin
                        state_d    = ST_ADDRESS;
                        burst_d    = burst_req_s;
                        ar_len_d   = 8'(burst_req_s - CNT_W'(1));
                        ar_valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADDRESS: begin
                if (ar_valid_q && src_ar_ready) begin
                    ar_valid_d    = 1'b0;
                    src_r_ready_d = 1'b1;
                    wr_ptr_d      = {IDX_W{1'b0}};
                    addr_d        = addr_q + (ADDR_WIDTH'(burst_q) << SIZE_LOG2);
                    remaining_d   = remaining_q - LEN_WIDTH'(burst_q);
                    state_d       = ST_READ;
                end else begin
                    state_d = ST_ADDRESS;
                end
            end

            ST_READ: begin
                if (src_r_valid && src_r_ready_q) begin
                    buf_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    if (src_r_resp != RESP_OKAY) begin
                        r_err_d = 1'b1;
                    end else begin
                        r_err_d = r_err_q;
                    end
                    // beat count decides the end of burst; r_last only shortens it
                    if (src_r_last || wr_last_s) begin
                        src_r_ready_d = 1'b0;
                        rd_ptr_d      = {IDX_W{1'b0}};
                        t_valid_d     = 1'b1;
                        t_last_d      = (burst_q == CNT_W'(1)) && (remaining_q == LEN_WIDTH'(0));
                        state_d       = ST_STREAM;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end

            ST_STREAM: begin
                if (t_valid_q && dest_t_ready) begin
                    if (rd_last_s) begin
                        t_valid_d = 1'b0;
                        t_last_d  = 1'b0;
                        if (remaining_q != LEN_WIDTH'(0)) begin
                            state_d    = ST_ADDRESS;
                            burst_d    = burst_rem_s;
                            ar_len_d   = 8'(burst_rem_s - CNT_W'(1));
                            ar_valid_d = 1'b1;
                        end else begin
                            r_ready_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_W'(1);
                        t_last_d = ((CNT_W'(rd_ptr_q) + CNT_W'(2)) == burst_q) &&
                                   (remaining_q == LEN_WIDTH'(0));
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            remaining_q   <= {LEN_WIDTH{1'b0}};
            burst_q       <= {CNT_W{1'b0}};
            wr_ptr_q      <= {IDX_W{1'b0}};
            rd_ptr_q      <= {IDX_W{1'b0}};
            ar_len_q      <= 8'd0;
            ar_valid_q    <= 1'b0;
            src_r_ready_q <= 1'b0;
            t_valid_q     <= 1'b0;
            t_last_q      <= 1'b0;
            r_ready_q     <= 1'b1;
            r_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            burst_q       <= burst_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ar_len_q      <= ar_len_d;
            ar_valid_q    <= ar_valid_d;
            src_r_ready_q <= src_r_ready_d;
            t_valid_q     <= t_valid_d;
            t_last_q      <= t_last_d;
            r_ready_q     <= r_ready_d;
            r_err_q       <= r_err_d;
        end
    end

    nasti_burst_buffer #(
        .DEPTH      (MAX_BURST_LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_buffer (
        .clk_i   (aclk),
        .rst_i   (areset),
        .we_i    (buf_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (src_r_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (dest_t_data)
    );

    assign src_ar_id    = {ID_WIDTH{1'b0}};
    assign src_ar_addr  = addr_q;
    assign src_ar_len   = ar_len_q;
    assign src_ar_size  = 3'(SIZE_LOG2);
    assign src_ar_burst = BURST_INCR;
    assign src_ar_lock  = 1'b0;
    assign src_ar_cache = 4'd0;
    assign src_ar_prot  = 3'd0;
    assign src_ar_valid = ar_valid_q;
    assign src_r_ready  = src_r_ready_q;
    assign src_aw_valid = 1'b0;
    assign src_w_valid  = 1'b0;
    assign src_b_ready  = 1'b0;

    assign dest_t_valid = t_valid_q;
    assign dest_t_last  = t_last_q;
    assign dest_t_keep  = {STRB_W{1'b1}};
    assign dest_t_strb  = {STRB_W{1'b1}};

    assign r_ready = r_ready_q;
    assign r_err   = r_err_q;

endmodule
